phase_clock_sequencer: RTL

//  Parametrised multi-phase clock generator with run/halt/single-step control.

---
 rtl/phase_clock_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/phase_clock_sequencer.sv
// rtl/phase_clock_sequencer.sv - multi-phase clock sequencer with run/halt/single-step control
//
// Purpose:
//   Divides rawclk by DIVIDE and rotates a one-hot ring of PHASES phase clocks.
//   A halt request stops the ring only at a machine-cycle boundary. A single step
//   runs exactly one full machine cycle and then stops.
//
// Ports:
//   rawclk     in   1       sole clock; all state changes on posedge
//   reset      in   1       asynchronous, active-low; clears all state
//   run        in   1       level; start free-running
//   nhalt      in   1       active-low level; stop at end of current cycle
//   step       in   1       rising edge starts one machine cycle
//   phase      out  PHASES  registered one-hot phase ring; zero when stopped
//   clk_out    out  1       registered; high during phases 0..PHASES/2-1
//   running    out  1       registered; high in any state other than stopped
//   cycle_end  out  1       registered one-rawclk pulse after each ring wrap
module phase_clock_sequencer #(
  parameter int PHASES = 4,
  parameter int DIVIDE = 2,
  parameter int PW     = (DIVIDE > 1) ? $clog2(DIVIDE) : 1
) (
  input  logic              rawclk,
  input  logic              reset,
  input  logic              run,
  input  logic              nhalt,
  input  logic              step,
  output logic [PHASES-1:0] phase,
  output logic              clk_out,
  output logic              running,
  output logic              cycle_end
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2,
    ST_STEPPING = 2'd3
  } state_t;

  localparam logic [PW-1:0]     PRE_LAST    = PW'(DIVIDE - 1);
  localparam logic [PHASES-1:0] PHASE_FIRST = {{(PHASES-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [PW-1:0]     pre, pre_n;
  logic              step_q;
  logic [PHASES-1:0] phase_n;
  logic [PHASES-1:0] phase_rot;
  logic              step_re;
  logic              tick;
  logic              wrap;
  logic              clk_n;

  assign step_re   = step & ~step_q;
  assign tick      = (state != ST_STOPPED) && (pre == PRE_LAST);
  // The last phase ending is the only legal point to stop the ring.
  assign wrap      = tick & phase[PHASES-1];
  assign phase_rot = {phase[PHASES-2:0], phase[PHASES-1]};

  always_comb begin
    state_n = state;
    phase_n = phase;
    case (state)
      ST_STOPPED: begin
        phase_n = '0;
        // Halt has priority over both run and step while stopped.
        if (nhalt) begin
          if (run) begin
            state_n = ST_RUNNING;
            phase_n = PHASE_FIRST;
          end else if (step_re) begin
            state_n = ST_STEPPING;
            phase_n = PHASE_FIRST;
          end
        end
      end
      ST_RUNNING: begin
        if (!nhalt && wrap) begin
          state_n = ST_STOPPED;
          phase_n = '0;
        end else begin
          if (!nhalt) state_n = ST_STOPPING;
          if (tick)   phase_n = phase_rot;
        end
      end
      ST_STOPPING: begin
        if (wrap) begin
          state_n = ST_STOPPED;
          phase_n = '0;
        end else begin
          if (run && nhalt) state_n = ST_RUNNING;
          if (tick)         phase_n = phase_rot;
        end
      end
      ST_STEPPING: begin
        if (wrap) begin
          state_n = ST_STOPPED;
          phase_n = '0;
        end else if (tick) begin
          phase_n = phase_rot;
        end
      end
      default: begin
        state_n = ST_STOPPED;
        phase_n = '0;
      end
    endcase
  end

  // Prescaler restarts from zero whenever the ring starts or stops.
  always_comb begin
    pre_n = pre + PW'(1);
    if (state == ST_STOPPED || state_n == ST_STOPPED || tick) pre_n = '0;
  end

  // clk_out is derived from the next phase so both load on the same edge.
  assign clk_n = |phase_n[PHASES/2-1:0];

  always_ff @(posedge rawclk or negedge reset) begin
    if (!reset) begin
      state     <= ST_STOPPED;
      pre       <= '0;
      step_q    <= 1'b0;
      phase     <= '0;
      clk_out   <= 1'b0;
      running   <= 1'b0;
      cycle_end <= 1'b0;
    end else begin
      state     <= state_n;
      pre       <= pre_n;
      step_q    <= step;
      phase     <= phase_n;
      clk_out   <= clk_n;
      running   <= (state_n != ST_STOPPED);
      cycle_end <= wrap;
    end
  end

endmodule
